// File: rtl/vend_pkg.sv
// Shared types and constants for the vend dispatcher.
// Holds the job FSM state encoding, the change coin value, and the vend counter width.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOTOR  = 2'd1,
        CHANGE = 2'd2,
        FAULT  = 2'd3
    } vend_state_e;

    // Value of the single change coin ejected per change-owing job.
    localparam int unsigned COIN_VALUE = 32'd5;

    // Width of the completed-vend counter output.
    localparam int unsigned VEND_CNT_W = 32'd16;

endpackage

// File: rtl/vend_job_fifo.sv
// Pending-job queue for the vend dispatcher.
// One bit per job (change owed). A push into a full queue is accepted only
// when a pop happens in the same cycle; otherwise it is silently refused and
// the caller decides what to do about the lost job.
module vend_job_fifo #(
    parameter int unsigned DEPTH = 32'd4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     data_i,
    input  logic                     pop_i,
    output logic                     data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == {(AW+1){1'b0}});
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop_ok_s  = pop_i & ~empty_o;
        push_ok_s = push_i & (~full_o | pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= {DEPTH{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vend_dispatcher.sv
// Vend dispatcher: queues dispense/change pulses from the seller FSM and runs
// each job through the dispense motor (with completion handshake and timeout)
// and, when change is owed, the coin hopper.
// Optional feature: define VEND_COUNTER_EN to build the 16-bit completed-vend
// counter; without it vend_count is tied to zero.
module vend_dispatcher
    import vend_pkg::*;
#(
    parameter int unsigned MOTOR_TIMEOUT = 32'd1000,
    parameter int unsigned COIN_PULSE    = 32'd4,
    parameter int unsigned JOB_DEPTH     = 32'd4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dispense,
    input  logic                          change,
    input  logic                          motor_done,
    input  logic                          fault_clr,
    output logic                          motor_on,
    output logic                          coin_out,
    output logic                          busy,
    output logic                          fault,
    output logic                          overflow,
    output logic [$clog2(JOB_DEPTH):0]    pending,
    output logic [VEND_CNT_W-1:0]         vend_count
);

    localparam int unsigned TMR_W  = $clog2(MOTOR_TIMEOUT + 32'd1);
    localparam int unsigned COIN_W = $clog2(COIN_PULSE + 32'd1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(MOTOR_TIMEOUT - 32'd1);
    localparam logic [COIN_W-1:0] COIN_LAST = COIN_W'(COIN_PULSE - 32'd1);

    vend_state_e       state_q;
    vend_state_e       state_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic [COIN_W-1:0] coin_cnt_q;
    logic [COIN_W-1:0] coin_cnt_d;
    logic              chg_owed_q;
    logic              chg_owed_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              motor_on_q;
    logic              coin_out_q;
    logic              fault_q;
    logic              pop_s;
    logic              vend_done_s;
    logic              fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [$clog2(JOB_DEPTH):0] fifo_count_s;

    vend_job_fifo #(
        .DEPTH (JOB_DEPTH)
    ) u_job_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dispense),
        .data_i  (change),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Job FSM next-state: start jobs, supervise the motor, time the coin pulse, hold on fault.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        coin_cnt_d  = coin_cnt_q;
        chg_owed_d  = chg_owed_q;
        pop_s       = 1'b0;
        vend_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    chg_owed_d = fifo_head_s;
                    timer_d    = {TMR_W{1'b0}};
                    state_d    = MOTOR;
                end else begin
                    state_d = IDLE;
                end
            end
            MOTOR: begin
                // Delivery wins over a timeout landing on the same cycle.
                if (motor_done) begin
                    vend_done_s = 1'b1;
                    coin_cnt_d  = {COIN_W{1'b0}};
                    state_d     = chg_owed_q ? CHANGE : IDLE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            CHANGE: begin
                if (coin_cnt_q == COIN_LAST) begin
                    state_d = IDLE;
                end else begin
                    coin_cnt_d = coin_cnt_q + COIN_W'(1);
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d = IDLE;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow: a job lost to a full queue outranks a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (dispense && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else if (fault_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, timers and the decoded drive outputs (registered so they never glitch).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= {TMR_W{1'b0}};
            coin_cnt_q <= {COIN_W{1'b0}};
            chg_owed_q <= 1'b0;
            overflow_q <= 1'b0;
            motor_on_q <= 1'b0;
            coin_out_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            coin_cnt_q <= coin_cnt_d;
            chg_owed_q <= chg_owed_d;
            overflow_q <= overflow_d;
            motor_on_q <= (state_d == MOTOR);
            coin_out_q <= (state_d == CHANGE);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign motor_on = motor_on_q;
    assign coin_out = coin_out_q;
    assign fault    = fault_q;
    assign overflow = overflow_q;
    assign pending  = fifo_count_s;
    assign busy     = (state_q != IDLE) | ~fifo_empty_s;

`ifdef VEND_COUNTER_EN
    logic [VEND_CNT_W-1:0] vend_cnt_q;

    // Completed-vend counter, wraps at full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vend_cnt_q <= {VEND_CNT_W{1'b0}};
        end else if (vend_done_s) begin
            vend_cnt_q <= vend_cnt_q + VEND_CNT_W'(1);
        end else begin
            vend_cnt_q <= vend_cnt_q;
        end
    end

    assign vend_count = vend_cnt_q;
`else
    logic unused_vend_done_s;
    assign unused_vend_done_s = vend_done_s;
    assign vend_count         = {VEND_CNT_W{1'b0}};
`endif

endmodule
